// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin sequencer sharing the data memory between the CPU and DMA ports,
// with registered glitch-free strobes and a one-cycle ack per access.
module data_mem_arbiter #(
    parameter int bit_size = 15,
    parameter int addr_size = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0,
    input  logic                we0,
    input  logic [addr_size:0]  addr0,
    input  logic [bit_size:0]   wdata0,
    output logic                ack0,
    output logic [bit_size:0]   rdata0,
    input  logic                req1,
    input  logic                we1,
    input  logic [addr_size:0]  addr1,
    input  logic [bit_size:0]   wdata1,
    output logic                ack1,
    output logic [bit_size:0]   rdata1,
    output logic                dataMemRead,
    output logic                dataMemWrite,
    output logic [addr_size:0]  address,
    output logic [bit_size:0]   value,
    input  logic [bit_size:0]   memOut,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_next;
    logic gnt, last_grant, pick, pick_we, start;
    logic [addr_size:0] pick_addr;
    logic [bit_size:0] pick_wdata;

    // On a tie the port that did not win last time goes next
    always_comb begin
        start = state == IDLE && (req0 || req1);
        pick = (req0 && req1) ? !last_grant : req1;
        pick_we = pick ? we1 : we0;
        pick_addr = pick ? addr1 : addr0;
        pick_wdata = pick ? wdata1 : wdata0;
        state_next = IDLE;
        case (state)
            IDLE:    state_next = start ? ACCESS : IDLE;
            ACCESS:  state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt <= 1'b0;
            last_grant <= 1'b1;
            address <= '0;
            value <= '0;
            dataMemRead <= 1'b0;
            dataMemWrite <= 1'b0;
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
            busy <= 1'b0;
        end else begin
            busy <= state_next != IDLE;
            dataMemRead <= start && !pick_we;
            dataMemWrite <= start && pick_we;
            ack0 <= state == ACCESS && !gnt;
            ack1 <= state == ACCESS && gnt;
            if (start) begin
                gnt <= pick;
                address <= pick_addr;
                value <= pick_wdata;
            end
            if (state == ACCESS) begin
                last_grant <= gnt;
                if (dataMemRead && !gnt) rdata0 <= memOut;
                if (dataMemRead && gnt) rdata1 <= memOut;
            end
        end
    end
endmodule
